// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared across the CPU datapath/control blocks.
//   WORD_W       : datapath word width (ALU BR/MR, ACC, memory buffer)
//   DROP_CNT_W   : width of the write-back dropped-start counter
//   wb_state_t   : state encoding of the accumulator write-back sequencer
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_W     = 16;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_RD_BR = 2'd1,
        WB_RD_MR = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_t;

endpackage : cpu_pkg

// File: rtl/acc_writeback.sv
// ----------------------------------------------------------------------------
// acc_writeback
// Accumulator and ALU result write-back sequencer, directly downstream of the
// ALU. ACC drives the ALU P operand. After an ALU operation the sequencer
// raises c9 (BR onto the bus), then c10 (MR onto the bus) for a multiply,
// one per cycle and never together, captures the bus words into ACC/ACC_HI
// and pulses done back to the control unit.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_start      1-cycle pulse: ALU result registered
//   i_is_mpy     sampled with i_start; 1 = also fetch MR into ACC_HI
//   i_br         ALU BR bus (valid while o_c9 = 1)
//   i_mr         ALU MR bus (valid while o_c10 = 1)
//   i_mbr        memory buffer word for LOAD
//   i_load_acc   ACC <= i_mbr (idle only)
//   i_clr_acc    ACC <= 0, ACC_HI <= 0 (idle only, wins over load)
//   o_c9         BR -> bus enable
//   o_c10        MR -> bus enable
//   o_acc        accumulator, feeds ALU P input
//   o_acc_hi     high word of the last multiply result
//   o_busy       sequencer not idle
//   o_done       1-cycle pulse: write-back complete
//   o_drop_cnt   count of i_start pulses seen while busy
//
// Build option
//   ACC_WB_DROP_CNT_EN : when defined, o_drop_cnt counts starts received while
//                        busy (saturating, cleared by reset and by an accepted
//                        i_clr_acc). When undefined, o_drop_cnt is 8'h00.
// ----------------------------------------------------------------------------
module acc_writeback
    import cpu_pkg::*;
#(
    parameter int WIDTH         = WORD_W,
    parameter bit CLR_HI_NONMPY = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_is_mpy,
    input  logic [WIDTH-1:0]      i_br,
    input  logic [WIDTH-1:0]      i_mr,
    input  logic [WIDTH-1:0]      i_mbr,
    input  logic                  i_load_acc,
    input  logic                  i_clr_acc,
    output logic                  o_c9,
    output logic                  o_c10,
    output logic [WIDTH-1:0]      o_acc,
    output logic [WIDTH-1:0]      o_acc_hi,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    wb_state_t        state_reg;
    wb_state_t        state_next;
    logic             mpy_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_hi_reg;

    logic idle;
    logic clr_accept;

    assign idle       = (state_reg == WB_IDLE);
    // A start in the same cycle pre-empts a pending load/clear.
    assign clr_accept = idle && !i_start && i_clr_acc;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= WB_IDLE;
            mpy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (idle && i_start) begin
                mpy_reg <= i_is_mpy;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WB_IDLE:  if (i_start) state_next = WB_RD_BR;
            WB_RD_BR: state_next = mpy_reg ? WB_RD_MR : WB_DONE;
            WB_RD_MR: state_next = WB_DONE;
            WB_DONE:  state_next = WB_IDLE;
            default:  state_next = WB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // ACC / ACC_HI
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_reg    <= '0;
            acc_hi_reg <= '0;
        end else begin
            case (state_reg)
                WB_IDLE: begin
                    if (clr_accept) begin
                        acc_reg    <= '0;
                        acc_hi_reg <= '0;
                    end else if (!i_start && i_load_acc) begin
                        acc_reg <= i_mbr;
                    end
                end
                WB_RD_BR: acc_reg    <= i_br;
                WB_RD_MR: acc_hi_reg <= i_mr;
                WB_DONE: begin
                    // A non-multiply result has no high word; optionally
                    // clear the stale one from an earlier multiply.
                    if (!mpy_reg && CLR_HI_NONMPY) begin
                        acc_hi_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional dropped-start counter
    // ------------------------------------------------------------------
`ifdef ACC_WB_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt_reg <= '0;
        end else if (clr_accept) begin
            drop_cnt_reg <= '0;
        end else if (!idle && i_start && (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign o_drop_cnt = drop_cnt_reg;
`else
    assign o_drop_cnt = '0;
`endif

    // All outputs come straight from registers: no input-to-output path.
    assign o_c9     = (state_reg == WB_RD_BR);
    assign o_c10    = (state_reg == WB_RD_MR);
    assign o_done   = (state_reg == WB_DONE);
    assign o_busy   = !idle;
    assign o_acc    = acc_reg;
    assign o_acc_hi = acc_hi_reg;

endmodule : acc_writeback

// File: tb/tb_acc_writeback.sv
// ----------------------------------------------------------------------------
// tb_acc_writeback
// Self-checking bench for acc_writeback. A transaction-level model tracks
// when each accepted write-back started and derives every output from the
// documented latencies; a compare process checks all outputs every cycle.
// Directed checks with literal values pin the model. Honours
// ACC_WB_DROP_CNT_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_acc_writeback;
    import cpu_pkg::*;

    localparam bit CLR_HI = 1'b1;
`ifdef ACC_WB_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start, i_is_mpy, i_load_acc, i_clr_acc;
    logic [15:0] i_br, i_mr, i_mbr;
    logic        o_c9, o_c10, o_busy, o_done;
    logic [15:0] o_acc, o_acc_hi;
    logic [7:0]  o_drop_cnt;

    always #5 i_clk = ~i_clk;

    acc_writeback #(.WIDTH(16), .CLR_HI_NONMPY(CLR_HI)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_is_mpy   (i_is_mpy),
        .i_br       (i_br),
        .i_mr       (i_mr),
        .i_mbr      (i_mbr),
        .i_load_acc (i_load_acc),
        .i_clr_acc  (i_clr_acc),
        .o_c9       (o_c9),
        .o_c10      (o_c10),
        .o_acc      (o_acc),
        .o_acc_hi   (o_acc_hi),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_drop_cnt (o_drop_cnt)
    );

    // The ALU puts its words on the bus only while enabled.
    logic [15:0] br_word, mr_word;
    assign i_br = o_c9  ? br_word : 16'h0000;
    assign i_mr = o_c10 ? mr_word : 16'h0000;

    // ---------------- model ----------------
    int          cyc;         // rising edges taken while out of reset
    int          seq_start;   // cyc value at which the current start was accepted
    bit          seq_valid;
    bit          seq_mpy;
    logic [15:0] m_acc, m_acc_hi;
    int          m_drop;
    bit          chk_en;

    int n_cmp, n_bad;

    function automatic int m_k();
        return cyc - seq_start;
    endfunction

    function automatic int m_len();
        return seq_mpy ? 3 : 2;
    endfunction

    function automatic bit m_busy();
        return seq_valid && (m_k() >= 1) && (m_k() <= m_len());
    endfunction

    task automatic model_reset();
        seq_valid = 1'b0;
        seq_mpy   = 1'b0;
        seq_start = 0;
        m_acc     = 16'h0000;
        m_acc_hi  = 16'h0000;
        m_drop    = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply inputs for one cycle (called just after a falling edge), advance
    // the model across the coming rising edge, then wait for the next fall.
    task automatic step(input bit s, input bit m, input bit ld, input bit cl,
                        input logic [15:0] mbr);
        int k;
        i_start    = s;
        i_is_mpy   = m;
        i_load_acc = ld;
        i_clr_acc  = cl;
        i_mbr      = mbr;
        k = m_k();
        if (m_busy()) begin
            if (s && DROP_EN && m_drop < 255) m_drop++;
            if (k == 1) m_acc = br_word;
            if (k == 2 && seq_mpy) m_acc_hi = mr_word;
            if (k == m_len() && !seq_mpy && CLR_HI) m_acc_hi = 16'h0000;
        end else if (s) begin
            seq_valid = 1'b1;
            seq_start = cyc;
            seq_mpy   = m;
            $display("wb start: mpy=%0d br=%h mr=%h", m, br_word, mr_word);
        end else if (cl) begin
            m_acc    = 16'h0000;
            m_acc_hi = 16'h0000;
            m_drop   = 0;
        end else if (ld) begin
            m_acc = mbr;
        end
        cyc++;
        @(negedge i_clk);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge i_clk) begin
        #2;
        if (chk_en && i_rst_n) begin
            chk("c9",   {31'd0, o_c9},   {31'd0, m_busy() && m_k() == 1});
            chk("c10",  {31'd0, o_c10},  {31'd0, m_busy() && seq_mpy && m_k() == 2});
            chk("done", {31'd0, o_done}, {31'd0, m_busy() && m_k() == m_len()});
            chk("busy", {31'd0, o_busy}, {31'd0, m_busy()});
            chk("acc",    {16'd0, o_acc},    {16'd0, m_acc});
            chk("acc_hi", {16'd0, o_acc_hi}, {16'd0, m_acc_hi});
            chk("drop",   {24'd0, o_drop_cnt}, m_drop);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; chk_en = 1'b0;
        i_rst_n = 1'b0;
        i_start = 0; i_is_mpy = 0; i_load_acc = 0; i_clr_acc = 0; i_mbr = '0;
        br_word = '0; mr_word = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_acc",    {16'd0, o_acc},    32'h0);
        chk("rst_acc_hi", {16'd0, o_acc_hi}, 32'h0);
        chk("rst_c9",     {31'd0, o_c9},     32'h0);
        chk("rst_c10",    {31'd0, o_c10},    32'h0);
        chk("rst_busy",   {31'd0, o_busy},   32'h0);
        chk("rst_done",   {31'd0, o_done},   32'h0);
        chk("rst_drop",   {24'd0, o_drop_cnt}, 32'h0);
        i_rst_n = 1'b1;
        chk_en  = 1'b1;

        // LOAD
        step(0, 0, 1, 0, 16'h1234);
        chk("load_acc",  {16'd0, o_acc}, 32'h1234);
        chk("load_busy", {31'd0, o_busy}, 32'h0);

        // Non-MPY write-back
        br_word = 16'h00A5;
        step(1, 0, 0, 0, 16'h0);
        chk("nm_c9_T1",  {31'd0, o_c9},  32'h1);
        chk("nm_c10_T1", {31'd0, o_c10}, 32'h0);
        step(0, 0, 0, 0, 16'h0);
        chk("nm_c9_T2",   {31'd0, o_c9},   32'h0);
        chk("nm_c10_T2",  {31'd0, o_c10},  32'h0);
        chk("nm_done_T2", {31'd0, o_done}, 32'h1);
        chk("nm_acc",     {16'd0, o_acc},  32'h00A5);
        step(0, 0, 0, 0, 16'h0);
        chk("nm_done_T3", {31'd0, o_done}, 32'h0);
        chk("nm_acc_hi",  {16'd0, o_acc_hi}, 32'h0);

        // MPY write-back
        br_word = 16'h5678; mr_word = 16'h0012;
        step(1, 1, 0, 0, 16'h0);
        chk("m_c9_T1",  {31'd0, o_c9},  32'h1);
        chk("m_c10_T1", {31'd0, o_c10}, 32'h0);
        step(0, 0, 0, 0, 16'h0);
        chk("m_c9_T2",   {31'd0, o_c9},   32'h0);
        chk("m_c10_T2",  {31'd0, o_c10},  32'h1);
        chk("m_done_T2", {31'd0, o_done}, 32'h0);
        chk("m_acc",     {16'd0, o_acc},  32'h5678);
        step(0, 0, 0, 0, 16'h0);
        chk("m_done_T3", {31'd0, o_done}, 32'h1);
        chk("m_acc_hi",  {16'd0, o_acc_hi}, 32'h0012);
        step(0, 0, 0, 0, 16'h0);

        // Start together with load: load dropped; non-MPY clears the old high word
        br_word = 16'h0BEE;
        step(1, 0, 1, 0, 16'hFFFF);
        step(0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 16'h0);
        chk("sl_acc",    {16'd0, o_acc},    32'h0BEE);
        chk("sl_acc_hi", {16'd0, o_acc_hi}, 32'h0);

        // Three starts while busy
        br_word = 16'hCAFE; mr_word = 16'hBEEF;
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        chk("drop3",      {24'd0, o_drop_cnt}, DROP_EN ? 32'd3 : 32'd0);
        chk("drop_acc",   {16'd0, o_acc},    32'hCAFE);
        chk("drop_acc_hi",{16'd0, o_acc_hi}, 32'hBEEF);
        chk("drop_idle",  {31'd0, o_busy},   32'h0);

        // Reset during RD_MR
        br_word = 16'h1111; mr_word = 16'h2222;
        step(1, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 16'h0);
        chk("pre_rst_c10", {31'd0, o_c10}, 32'h1);
        #1 i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_c10",    {31'd0, o_c10},    32'h0);
        chk("arst_acc",    {16'd0, o_acc},    32'h0);
        chk("arst_acc_hi", {16'd0, o_acc_hi}, 32'h0);
        chk("arst_busy",   {31'd0, o_busy},   32'h0);
        chk("arst_drop",   {24'd0, o_drop_cnt}, 32'h0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 16'h0);
            chk("no_done_after_rst", {31'd0, o_done}, 32'h0);
        end

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if (!m_busy()) begin
                br_word = 16'($urandom);
                mr_word = 16'($urandom);
            end
            step(($urandom_range(3) == 0), $urandom_range(1), ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0), 16'($urandom));
        end

        // Continuous starts drive the drop counter to saturation
        for (int i = 0; i < 900; i++) begin
            if (!m_busy()) begin
                br_word = 16'($urandom);
                mr_word = 16'($urandom);
            end
            step(1, $urandom_range(1), 0, 0, 16'h0);
        end
        chk("drop_sat", {24'd0, o_drop_cnt}, DROP_EN ? 32'hFF : 32'h0);

        // Let the last sequence finish, then clear
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0);
        chk("clr_acc",  {16'd0, o_acc},      32'h0);
        chk("clr_drop", {24'd0, o_drop_cnt}, 32'h0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_acc_writeback
